addsub_serial: RTL and testbench
================================

// Module: addsub_serial
// PURPOSE
//   Parametrised multi-cycle add/subtract unit; successor to the fixed 8-bit ripple subtractor.
//   Computes A+B or A-B (two's complement: ~B with carry-in 1) over WIDTH bits.
//   Processes DIGIT bits per clock through a DIGIT-bit ripple slice, trading latency for area.
//   Valid/ready handshake on both sides; produces carry, overflow, zero and negative flags.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 2.
//   DIGIT  2  bits processed per cycle; must divide WIDTH exactly (elaboration $error otherwise).
// PORTS
//   clk        in   1      rising-edge clock.
//   rst_n      in   1      asynchronous, active-low reset.
//   in_valid   in   1      operands and op are valid.
//   in_ready   out  1      unit can accept a new operation.
//   op         in   1      0 = add (A+B), 1 = subtract (A-B).
//   A          in   WIDTH  operand A.
//   B          in   WIDTH  operand B.
//   out_valid  out  1      result and flags are valid.
//   out_ready  in   1      consumer accepts the result.
//   Y          out  WIDTH  result.
//   carry      out  1      carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
//   ovf        out  1      signed overflow.
//   zero       out  1      Y == 0.
//   neg        out  1      Y[WIDTH-1].
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; Y=0; carry=ovf=zero=neg=0; counter=0.
//   States:
//     IDLE: in_ready=1. On in_valid=1, latch A, B^{WIDTH{op}}, op. Set carry reg = op. cnt=0. Go to RUN.
//     RUN: in_ready=0. Each cycle, add DIGIT LSBs via ripple slice with carry reg.
//       Shift the DIGIT sum bits into the result register from the MSB side. Shift operands right by DIGIT.
//       Store the slice carry-out. cnt++.
//       On the last digit (cnt == WIDTH/DIGIT-1), capture:
//         carry = MSB carry-out.
//         ovf = carry into MSB XOR carry out of MSB.
//       Then go to DONE.
//     DONE: out_valid=1; Y and flags stable. On out_ready=1, go to IDLE next cycle (out_valid drops).
//   Latency: accept edge -> out_valid high after WIDTH/DIGIT+1 clocks.
//     Defaults: 5 clocks.
//     Throughput: one op per WIDTH/DIGIT+2 clocks when out_ready is tied high.
//   Arithmetic: all modulo 2^WIDTH. zero and neg are computed from final Y (after saturation if enabled).
//   Boundaries:
//     - in_valid during RUN/DONE is ignored; the producer must hold it until in_ready is seen.
//     - No accept in the same cycle as the DONE->IDLE handoff; in_ready rises one cycle after out_ready.
//     - out_ready while not out_valid has no effect.
//     - out_valid held indefinitely with out_ready=0; Y/flags do not change.
//     - DIGIT == WIDTH degenerates to a single RUN cycle.
//     - rst_n low mid-RUN or in DONE aborts the operation immediately. No output is produced for it.
// CONFIGURATION
//   SATURATE_EN defined: when ovf=1 in DONE, Y is clamped to the signed limit.
//     Clamp to 2^(WIDTH-1)-1 if the true result is positive (sign of A, since A and effective B agree).
//     Otherwise clamp to -2^(WIDTH-1). ovf still reports 1.
//     carry is unaffected.
//   SATURATE_EN undefined: Y is the wrapped modulo result. No clamp logic is synthesised.
// TESTING
//   Test bench uses WIDTH=8, DIGIT=2 unless stated.
//   1. Sub, A=8'h05, B=8'h03.
//      -> Y=8'h02, carry=1, ovf=0, zero=0, neg=0.
//      -> out_valid exactly 5 clocks after the accept edge.
//   2. Sub, A=8'h03, B=8'h05.
//      -> Y=8'hFE, carry=0, neg=1, ovf=0.
//   3. Add, A=8'h7F, B=8'h01.
//      -> Y=8'h80, ovf=1, neg=1.
//      -> With SATURATE_EN: Y=8'h7F, ovf=1, neg=0.
//   4. Sub, A=8'h80, B=8'h01.
//      -> Y=8'h7F, ovf=1, carry=1.
//      -> With SATURATE_EN: Y=8'h80.
//   5. Handshake:
//      - Hold out_ready=0 for 10 clocks: Y stable, in_ready=0.
//      - Raise out_ready: out_valid falls the next clock; in_ready rises.
//      - Back-to-back: second op is accepted the following clock.
//   6. Assert rst_n=0 at the 2nd RUN cycle of A=8'hAA, B=8'h55.
//      -> Immediately all outputs reset values, in_ready=1.
//      -> Next op A=8'h10+B=8'h20 gives Y=8'h30, zero=0.
//      -> Repeat with WIDTH=16, DIGIT=4: A=16'hFFFF+B=16'h0001 -> Y=0, zero=1, carry=1.

Source files
------------

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit with valid/ready handshakes and carry/ovf/zero/neg flags.
// Optional macro SATURATE_EN clamps an overflowed result to the signed limit.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("addsub_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [DIGIT-1:0] sum;
    logic             cout, cin_msb, last;
    logic [WIDTH-1:0] y_shift, y_final;

    // Ripple slice over the current low digit; on the last digit its top bit is the word MSB.
    always_comb begin
        {cout, sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
        cin_msb     = sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        last        = (cnt_q == CW'(NDIG - 1));
        y_shift     = (y_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
        y_final     = y_shift;
`ifdef SATURATE_EN
        // A and effective B share a sign when overflow occurs, so A's MSB gives the direction.
        if (cout ^ cin_msb) begin
            y_final = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{op}};
                    c_d     = op;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = cout;
                y_d   = y_shift;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    y_d     = y_final;
                    carry_d = cout;
                    ovf_d   = cout ^ cin_msb;
                    zero_d  = (y_final == '0);
                    neg_d   = y_final[WIDTH-1];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: an 8/2 and a 16/4 instance share stimulus and are checked
// against an integer-arithmetic reference model (honours SATURATE_EN when defined).
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, op, out_ready;
    logic [15:0] a, b;

    logic       in_ready8, out_valid8, c8, v8, z8, n8;
    logic [7:0] y8;
    logic        in_ready16, out_valid16, c16, v16, z16, n16;
    logic [15:0] y16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .op(op),
        .A(a[7:0]), .B(b[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
        .Y(y8), .carry(c8), .ovf(v8), .zero(z8), .neg(n8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .op(op),
        .A(a), .B(b), .out_valid(out_valid16), .out_ready(out_ready),
        .Y(y16), .carry(c16), .ovf(v16), .zero(z16), .neg(n16)
    );

    // Returns {Y[15:0], carry, ovf, zero, neg} for a w-bit operation.
    function automatic logic [19:0] model(input int w, input logic o, input logic [15:0] av,
                                          input logic [15:0] bv);
        longint m, half, ua, ub, sa, sb, r, yy;
        logic   c, v;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = o ? sa - sb : sa + sb;
        c    = o ? (ua >= ub) : (ua + ub > m);
        v    = (r >= half) || (r < -half);
        yy   = r & m;
`ifdef SATURATE_EN
        if (v) yy = (r > 0) ? half - 1 : half;
`endif
        return {yy[15:0], c, v, (yy == 0), yy[w-1]};
    endfunction

    function automatic logic [19:0] got8();
        return {8'h00, y8, c8, v8, z8, n8};
    endfunction

    function automatic logic [19:0] got16();
        return {y16, c16, v16, z16, n16};
    endfunction

    // Presents one operation, waits for accept, then waits (bounded) for out_valid.
    // lat counts falling edges from the accept edge to the first one seeing out_valid.
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] z,
                         output int lat);
        int k;
        @(negedge clk);
        op = o; a = x; b = z; in_valid = 1'b1;
        k = 0;
        while (!in_ready8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid8 !== 1'b1 || out_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: out_valid8=%b out_valid16=%b required 1", out_valid8,
                     out_valid16);
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if (in_ready8 !== 1'b1 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b required 1", in_ready8, in_ready16);
        end
        checks++;
        if (out_valid8 !== 1'b0 || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b/%b required 0", out_valid8, out_valid16);
        end
        checks++;
        if (got8() !== 20'h0 || got16() !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h required 0", got8(), got16());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic        ops [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] as  [4] = '{16'h05, 16'h03, 16'h7F, 16'h80};
        logic [15:0] bs  [4] = '{16'h03, 16'h05, 16'h01, 16'h01};
        logic [19:0] e8, e16;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], lat);
            e8  = model(8, ops[i], as[i], bs[i]);
            e16 = model(16, ops[i], as[i], bs[i]);
            checks++;
            if (got8() !== e8) begin
                errors++;
                $display("FAIL directed%0d_w8: got %h required %h", i, got8(), e8);
            end
            checks++;
            if (got16() !== e16) begin
                errors++;
                $display("FAIL directed%0d_w16: got %h required %h", i, got16(), e16);
            end
            if (i == 0) begin
                checks++;
                if (lat !== 5) begin
                    errors++;
                    $display("FAIL latency: got %0d clocks required 5", lat);
                end
            end
            release_out();
        end
    endtask

    task automatic test_handshake();
        logic [19:0] e8, e2;
        int lat, bad;
        do_op(1'b1, 16'h05, 16'h03, lat);
        e8 = model(8, 1'b1, 16'h05, 16'h03);
        // New operation presented while the result is parked must be ignored.
        op = 1'b0; a = 16'h11; b = 16'h22; in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || got8() !== e8) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, got %h required %h", bad, got8(), e8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL handoff: out_valid=%b in_ready=%b required 0/1", out_valid8, in_ready8);
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL next_accept: in_ready=%b required 0", in_ready8);
        end
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        e2 = model(8, 1'b0, 16'h11, 16'h22);
        checks++;
        if (got8() !== e2 || lat !== 5) begin
            errors++;
            $display("FAIL second_op: got %h lat %0d required %h lat 5", got8(), lat, e2);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int first, second, k;
        first = -1; second = -1;
        @(negedge clk);
        op = 1'b0; a = 16'h40; b = 16'h30; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (in_ready8) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (second - first !== 6) begin
            errors++;
            $display("FAIL throughput: accept gap %0d required 6", second - first);
        end
        k = 0;
        while (!in_ready8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int lat, k;
        @(negedge clk);
        op = 1'b0; a = 16'hAA; b = 16'h55; in_valid = 1'b1;
        k = 0;
        while (!in_ready8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || got8() !== 20'h0 ||
            in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || got16() !== 20'h0) begin
            errors++;
            $display("FAIL abort_reset: rdy=%b vld=%b out=%h required 1 0 0", in_ready8,
                     out_valid8, got8());
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 16'h10, 16'h20, lat);
        checks++;
        if (y8 !== 8'h30 || z8 !== 1'b0 || got8() !== model(8, 1'b0, 16'h10, 16'h20)) begin
            errors++;
            $display("FAIL after_abort: got %h required Y=30 zero=0", got8());
        end
        release_out();
        do_op(1'b0, 16'hFFFF, 16'h0001, lat);
        checks++;
        if (y16 !== 16'h0 || z16 !== 1'b1 || c16 !== 1'b1 ||
            got16() !== model(16, 1'b0, 16'hFFFF, 16'h0001)) begin
            errors++;
            $display("FAIL wide_wrap: got %h required Y=0 zero=1 carry=1", got16());
        end
        release_out();
    endtask

    task automatic test_random();
        logic        o;
        logic [15:0] x, z;
        logic [19:0] e8, e16;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            z = (i % 5 == 0) ? x : 16'($urandom);
            do_op(o, x, z, lat);
            e8  = model(8, o, x, z);
            e16 = model(16, o, x, z);
            checks++;
            if (got8() !== e8) begin
                errors++;
                $display("FAIL random%0d_w8: op=%b a=%h b=%h got %h required %h", i, o, x[7:0],
                         z[7:0], got8(), e8);
            end
            checks++;
            if (got16() !== e16) begin
                errors++;
                $display("FAIL random%0d_w16: op=%b a=%h b=%h got %h required %h", i, o, x, z,
                         got16(), e16);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
